// File: rtl/opf_chan_scheduler.sv
// opf_chan_scheduler: serializes per-channel PID samples into the shared
// output filter pipeline, one channel-tagged sample per clock.
// Each channel holds one pending sample (latest wins, sticky overwrite flag).
// Channels are picked round-robin. A per-channel reissue gap keeps two
// samples of one channel out of the filter's read-modify-write window.
// Optional build macro OPF_SCHED_PRIO_EN: channel 0 gets strict priority and
// does not move the round-robin pointer.
module opf_chan_scheduler #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned W_CHAN = 5,
  parameter int unsigned W_DATA = 18,
  parameter int unsigned GAP    = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_CHAN-1:0]          req_dv_in,
  input  logic [N_CHAN*W_DATA-1:0]   req_data_in,
  input  logic                       ovf_clr_in,
  output logic                       dv_out,
  output logic [W_CHAN-1:0]          chan_out,
  output logic signed [W_DATA-1:0]   data_out,
  output logic [N_CHAN-1:0]          pend_out,
  output logic [N_CHAN-1:0]          ovf_out
);

  localparam logic [3:0] GapReload = 4'(GAP - 1);

  logic [W_DATA-1:0] slot_q [N_CHAN];
  logic [3:0]        gap_q  [N_CHAN];
  logic [3:0]        gap_d  [N_CHAN];
  logic [N_CHAN-1:0] pend_q, pend_d;
  logic [N_CHAN-1:0] ovf_q, ovf_d;
  logic [N_CHAN-1:0] elig;
  logic [N_CHAN-1:0] issue_vec;
  logic [W_CHAN-1:0] ptr_q, ptr_d;
  logic [W_CHAN-1:0] sel;
  logic              found;
  logic              prio_hit;
  int unsigned       rr_idx;

  // A channel may issue when it has a sample and its reissue gap has expired
  always_comb begin
    for (int c = 0; c < int'(N_CHAN); c++) begin
      elig[c] = pend_q[c] && (gap_q[c] == 4'd0);
    end
  end

`ifdef OPF_SCHED_PRIO_EN
  assign prio_hit = elig[0];
`else
  assign prio_hit = 1'b0;
`endif

  // Arbitration: priority channel first (if enabled), else first eligible after the pointer
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    rr_idx = 0;
    if (prio_hit) begin
      found = 1'b1;
      sel   = '0;
    end else begin
      for (int unsigned i = 1; i <= N_CHAN; i++) begin
        rr_idx = 32'(ptr_q) + i;
        if (rr_idx >= N_CHAN) rr_idx = rr_idx - N_CHAN;
        if (!found && elig[rr_idx[W_CHAN-1:0]]) begin
          found = 1'b1;
          sel   = rr_idx[W_CHAN-1:0];
        end
      end
    end
  end

  // Per-channel next state: pending slot, overflow flag, gap counter
  always_comb begin
    for (int c = 0; c < int'(N_CHAN); c++) begin
      issue_vec[c] = found && (sel == W_CHAN'(c));
      // A request on the issuing edge refills the slot without counting as overflow
      pend_d[c] = req_dv_in[c] | (pend_q[c] & ~issue_vec[c]);
      // Set beats clear when both land on the same edge
      ovf_d[c]  = (req_dv_in[c] & pend_q[c] & ~issue_vec[c]) | (ovf_q[c] & ~ovf_clr_in);
      if (issue_vec[c]) begin
        gap_d[c] = GapReload;
      end else if (gap_q[c] != 4'd0) begin
        gap_d[c] = gap_q[c] - 4'd1;
      end else begin
        gap_d[c] = 4'd0;
      end
    end
    // Priority issues of channel 0 leave the round-robin position untouched
    ptr_d = (found && !prio_hit) ? sel : ptr_q;
  end

  // State and registered issue outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < int'(N_CHAN); c++) begin
        slot_q[c] <= '0;
        gap_q[c]  <= 4'd0;
      end
      pend_q   <= '0;
      ovf_q    <= '0;
      ptr_q    <= W_CHAN'(N_CHAN - 1);
      dv_out   <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
    end else begin
      for (int c = 0; c < int'(N_CHAN); c++) begin
        if (req_dv_in[c]) slot_q[c] <= req_data_in[c*W_DATA +: W_DATA];
        gap_q[c] <= gap_d[c];
      end
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      ptr_q  <= ptr_d;
      dv_out <= found;
      if (found) begin
        chan_out <= sel;
        data_out <= slot_q[sel];
      end
    end
  end

  assign pend_out = pend_q;
  assign ovf_out  = ovf_q;

endmodule

// File: tb/tb_opf_chan_scheduler.sv
// Scoreboard bench for opf_chan_scheduler: stimulus pushes expected
// {channel, data, cycle} tuples; a negedge monitor pops and compares on dv_out.
module tb_opf_chan_scheduler;

  localparam int N  = 8;
  localparam int WC = 5;
  localparam int WD = 18;
  localparam int GP = 4;

  typedef struct {
    int chan;
    int data;
    int cyc;
  } exp_t;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b1;
  logic [N-1:0]          req_dv_in = '0;
  logic [N*WD-1:0]       req_data_in = '0;
  logic                  ovf_clr_in = 1'b0;
  logic                  dv_out;
  logic [WC-1:0]         chan_out;
  logic signed [WD-1:0]  data_out;
  logic [N-1:0]          pend_out;
  logic [N-1:0]          ovf_out;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n;
  int   m;

  opf_chan_scheduler #(
    .N_CHAN (N),
    .W_CHAN (WC),
    .W_DATA (WD),
    .GAP    (GP)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req_dv_in   (req_dv_in),
    .req_data_in (req_data_in),
    .ovf_clr_in  (ovf_clr_in),
    .dv_out      (dv_out),
    .chan_out    (chan_out),
    .data_out    (data_out),
    .pend_out    (pend_out),
    .ovf_out     (ovf_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: value seen after edge k is k
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every issue must match the head of the scoreboard, including its cycle
  always @(negedge clk_in) begin
    if (dv_out === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_issue: got chan=%0d data=%0d at cyc=%0d, required no issue",
                 chan_out, data_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (int'(chan_out) == mon_e.chan && int'(data_out) == mon_e.data && cyc == mon_e.cyc)
          n_pass++;
        else
          $display("FAIL issue: got chan=%0d data=%0d cyc=%0d, required chan=%0d data=%0d cyc=%0d",
                   chan_out, data_out, cyc, mon_e.chan, mon_e.data, mon_e.cyc);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    req_dv_in  = '0;
    ovf_clr_in = 1'b0;
  endtask

  task automatic set_ch(input int c, input int v);
    req_dv_in[c] = 1'b1;
    req_data_in[c*WD +: WD] = WD'(v);
  endtask

  task automatic expect_issue(input int c, input int v, input int at);
    exp_t e;
    e.chan = c;
    e.data = v;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    chk("missing_issues", longint'(sb.size()), 0);
    sb.delete();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    chk("reset_dv", longint'(dv_out), 0);
    chk("reset_chan", longint'(chan_out), 0);
    chk("reset_data", longint'(data_out), 0);
    chk("reset_pend", longint'(pend_out), 0);
    chk("reset_ovf", longint'(ovf_out), 0);

    // Single request on ch2
    n = cyc;
    set_ch(2, -5);
    expect_issue(2, -5, n + 2);
    tick();
    chk("single_pend_captured", longint'(pend_out), 64'h04);
    tick();
    chk("single_pend_cleared", longint'(pend_out), 0);
    repeat (4) tick();

    // All channels at once: round-robin 0..7 back to back
    do_reset();
    n = cyc;
    for (int c = 0; c < N; c++) begin
      set_ch(c, c * 10);
      expect_issue(c, c * 10, n + 2 + c);
    end
    tick();
    chk("rr_pend_all", longint'(pend_out), 64'hFF);
    repeat (10) tick();
    chk("rr_pend_drained", longint'(pend_out), 0);
    chk("rr_no_ovf", longint'(ovf_out), 0);

    // Gap enforcement: ch3 every cycle for 12 cycles
    do_reset();
    n = cyc;
    for (int j = 0; j < 3; j++) expect_issue(3, 100 + 4 * j, n + 2 + 4 * j);
    expect_issue(3, 111, n + 14);
    for (int i = 0; i < 12; i++) begin
      set_ch(3, 100 + i);
      tick();
    end
    chk("gap_ovf", longint'(ovf_out), 64'h08);
    repeat (6) tick();
    chk("gap_pend_drained", longint'(pend_out), 0);

    // Overflow, clear, coincident re-request, set-beats-clear
    do_reset();
    n = cyc;
    expect_issue(1, 11, n + 2);
    expect_issue(1, 33, n + 6);
    set_ch(1, 11);
    tick();
    tick();
    set_ch(1, 22);
    tick();
    set_ch(1, 33);
    tick();
    chk("ovf_set", longint'(ovf_out), 64'h02);
    ovf_clr_in = 1'b1;
    tick();
    chk("ovf_cleared", longint'(ovf_out), 0);
    repeat (5) tick();
    m = cyc;
    expect_issue(1, 44, m + 2);
    expect_issue(1, 55, m + 6);
    expect_issue(1, 77, m + 10);
    set_ch(1, 44);
    tick();
    set_ch(1, 55);
    tick();
    chk("coincident_no_ovf", longint'(ovf_out), 0);
    chk("coincident_pend", longint'(pend_out), 64'h02);
    repeat (4) tick();
    set_ch(1, 66);
    tick();
    set_ch(1, 77);
    ovf_clr_in = 1'b1;
    tick();
    chk("ovf_set_beats_clr", longint'(ovf_out), 64'h02);
    repeat (6) tick();

    // Asynchronous reset mid-cycle with 5 channels pending
    do_reset();
    n = cyc;
    for (int c = 1; c <= 5; c++) set_ch(c, c * 7);
    tick();
    for (int c = 1; c <= 5; c++) set_ch(c, c * 7 + 1);
    expect_issue(1, 7, n + 2);
    tick();
    chk("pre_reset_ovf", longint'(ovf_out), 64'h3C);
    chk("pre_reset_pend", longint'(pend_out), 64'h3E);
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    chk("async_rst_dv", longint'(dv_out), 0);
    chk("async_rst_pend", longint'(pend_out), 0);
    chk("async_rst_ovf", longint'(ovf_out), 0);
    #1;
    rst_in = 1'b0;
    repeat (10) tick();
    chk("post_rst_pend", longint'(pend_out), 0);

    // ch0 and ch5 every GAP period, then ch0 vs ch6 with pointer at 5
    do_reset();
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      expect_issue(0, 500 + k, n + 2 + 4 * k);
      expect_issue(5, -500 - k, n + 3 + 4 * k);
      set_ch(0, 500 + k);
      set_ch(5, -500 - k);
      tick();
      repeat (3) tick();
    end
    repeat (4) tick();
`ifdef OPF_SCHED_PRIO_EN
    expect_issue(0, 77, n + 18);
    expect_issue(6, 66, n + 19);
`else
    expect_issue(6, 66, n + 18);
    expect_issue(0, 77, n + 19);
`endif
    set_ch(0, 77);
    set_ch(6, 66);
    tick();
    repeat (6) tick();
    chk("final_missing_issues", longint'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
